// File: rtl/zn_mon_pkg.sv
// Shared types and helpers for the zn edge monitor.
// Counter widths up to 32 bits are supported by sat_inc.
package zn_mon_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        TRACK_LOW  = 2'd1,
        TRACK_HIGH = 2'd2
    } zn_mon_state_t;

    localparam int ZN_MON_CNT_W_DEF = 16;

    // Increment v, holding at the all-ones value of a w-bit counter.
    function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
        logic [31:0] max_v;
        max_v = (32'd1 << w) - 32'd1;
        return (v >= max_v) ? max_v : v + 32'd1;
    endfunction

endpackage

// File: rtl/zn_sync.sv
// Multi-flop synchronizer bringing the asynchronous zn level into the clk domain.
// SYNC_STAGES must be in 2..4.
module zn_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] stg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stg <= '0;
        end else begin
            stg <= {stg[SYNC_STAGES-2:0], d};
        end
    end

    assign q = stg[SYNC_STAGES-1];

endmodule

// File: rtl/zn_edge_monitor.sv
// Edge monitor for the inverter output zn: synchronizes zn, detects edges, keeps saturating
// edge counters and run lengths. ZN_EDGE_MONITOR_GLITCH_FILTER_EN adds a two-sample filter.
module zn_edge_monitor
    import zn_mon_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = ZN_MON_CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             zn,
    input  logic             clr,
    output logic             level,
    output logic             level_valid,
    output logic             rise_pulse,
    output logic             fall_pulse,
    output logic [CNT_W-1:0] rise_cnt,
    output logic [CNT_W-1:0] fall_cnt,
    output logic [CNT_W-1:0] run_len,
    output logic [CNT_W-1:0] last_run,
    output logic             last_run_valid,
    output logic [1:0]       state_dbg
);

    // Pulse semantics: rise_pulse, fall_pulse and last_run_valid are single-cycle qualifiers
    // with no back-pressure; the counts and last_run they accompany are valid in that cycle.

    zn_mon_state_t state, state_nxt;
    logic s;
    logic chg;

    logic             level_d, level_valid_d, rise_pulse_d, fall_pulse_d, last_run_valid_d;
    logic [CNT_W-1:0] rise_cnt_d, fall_cnt_d, run_len_d, last_run_d;

    zn_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (zn),
        .q     (s)
    );

`ifdef ZN_EDGE_MONITOR_GLITCH_FILTER_EN
    logic f;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            f <= 1'b0;
        end else begin
            f <= s;
        end
    end

    // Only a level seen on two consecutive samples counts as a change.
    assign chg = (s == f) && (s != level);
`else
    assign chg = (s != level);
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (clr) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:                  state_nxt = s ? TRACK_HIGH : TRACK_LOW;
                TRACK_LOW, TRACK_HIGH: if (chg) state_nxt = s ? TRACK_HIGH : TRACK_LOW;
                default:               state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        level_d          = level;
        level_valid_d    = level_valid;
        rise_pulse_d     = 1'b0;
        fall_pulse_d     = 1'b0;
        last_run_valid_d = 1'b0;
        rise_cnt_d       = rise_cnt;
        fall_cnt_d       = fall_cnt;
        run_len_d        = run_len;
        last_run_d       = last_run;
        // clr wins over an edge arriving in the same cycle: nothing is pulsed or counted.
        if (clr) begin
            level_valid_d = 1'b0;
            rise_cnt_d    = '0;
            fall_cnt_d    = '0;
            run_len_d     = '0;
            last_run_d    = '0;
        end else begin
            case (state)
                IDLE: begin
                    level_d       = s;
                    level_valid_d = 1'b1;
                    run_len_d     = CNT_W'(1);
                end
                TRACK_LOW, TRACK_HIGH: begin
                    if (chg) begin
                        level_d          = s;
                        rise_pulse_d     = s;
                        fall_pulse_d     = ~s;
                        if (s) begin
                            rise_cnt_d = CNT_W'(sat_inc(32'(rise_cnt), CNT_W));
                        end else begin
                            fall_cnt_d = CNT_W'(sat_inc(32'(fall_cnt), CNT_W));
                        end
                        last_run_d       = run_len;
                        last_run_valid_d = 1'b1;
                        run_len_d        = CNT_W'(1);
                    end else begin
                        run_len_d = CNT_W'(sat_inc(32'(run_len), CNT_W));
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            level          <= 1'b0;
            level_valid    <= 1'b0;
            rise_pulse     <= 1'b0;
            fall_pulse     <= 1'b0;
            last_run_valid <= 1'b0;
            rise_cnt       <= '0;
            fall_cnt       <= '0;
            run_len        <= '0;
            last_run       <= '0;
        end else begin
            level          <= level_d;
            level_valid    <= level_valid_d;
            rise_pulse     <= rise_pulse_d;
            fall_pulse     <= fall_pulse_d;
            last_run_valid <= last_run_valid_d;
            rise_cnt       <= rise_cnt_d;
            fall_cnt       <= fall_cnt_d;
            run_len        <= run_len_d;
            last_run       <= last_run_d;
        end
    end

    assign state_dbg = state;

endmodule

// File: tb/tb_zn_edge_monitor.sv
// Bench for zn_edge_monitor: directed phases plus random zn/clr/reset traffic, all checked
// against a sample-history reference model through snapshot and edge-event queues.
module tb_zn_edge_monitor;
    import zn_mon_pkg::*;

    localparam int SYNC_STAGES = 2;
    localparam int CNT_W       = 4;
    localparam int MAXV        = (1 << CNT_W) - 1;
`ifdef ZN_EDGE_MONITOR_GLITCH_FILTER_EN
    localparam bit FILT = 1'b1;
`else
    localparam bit FILT = 1'b0;
`endif
    localparam int LAT = SYNC_STAGES + (FILT ? 1 : 0);
    localparam int SW  = 5 + 4 * CNT_W;
    localparam int EW  = 1 + 3 * CNT_W;

    logic             clk;
    logic             rst_n;
    logic             zn;
    logic             clr;
    logic             level;
    logic             level_valid;
    logic             rise_pulse;
    logic             fall_pulse;
    logic [CNT_W-1:0] rise_cnt;
    logic [CNT_W-1:0] fall_cnt;
    logic [CNT_W-1:0] run_len;
    logic [CNT_W-1:0] last_run;
    logic             last_run_valid;
    logic [1:0]       state_dbg;

    zn_edge_monitor #(.SYNC_STAGES(SYNC_STAGES), .CNT_W(CNT_W)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .zn             (zn),
        .clr            (clr),
        .level          (level),
        .level_valid    (level_valid),
        .rise_pulse     (rise_pulse),
        .fall_pulse     (fall_pulse),
        .rise_cnt       (rise_cnt),
        .fall_cnt       (fall_cnt),
        .run_len        (run_len),
        .last_run       (last_run),
        .last_run_valid (last_run_valid),
        .state_dbg      (state_dbg)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard state
    logic [SW-1:0] exp_q[$];
    logic [EW-1:0] ev_q[$];
    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: zn samples taken at past edges, and the spec's tracking rules.
    bit m_hist[0:SYNC_STAGES];
    bit m_idle, m_lvl, m_lv, m_rp, m_fp, m_lrv;
    int m_rise, m_fall, m_run, m_last;

    function automatic int sat(input int v);
        return (v + 1 > MAXV) ? MAXV : v + 1;
    endfunction

    task automatic model_step(input bit r, input bit c, input bit z);
        bit s, f;
        m_rp  = 1'b0;
        m_fp  = 1'b0;
        m_lrv = 1'b0;
        if (!r) begin
            m_idle = 1'b1; m_lvl = 1'b0; m_lv = 1'b0;
            m_rise = 0; m_fall = 0; m_run = 0; m_last = 0;
            for (int i = 0; i <= SYNC_STAGES; i++) m_hist[i] = 1'b0;
        end else begin
            s = m_hist[SYNC_STAGES-1];
            f = m_hist[SYNC_STAGES];
            if (c) begin
                m_idle = 1'b1; m_lv = 1'b0;
                m_rise = 0; m_fall = 0; m_run = 0; m_last = 0;
            end else if (m_idle) begin
                m_idle = 1'b0; m_lvl = s; m_lv = 1'b1; m_run = 1;
            end else if (s != m_lvl && (!FILT || s == f)) begin
                if (s) begin m_rise = sat(m_rise); m_rp = 1'b1; end
                else   begin m_fall = sat(m_fall); m_fp = 1'b1; end
                m_last = m_run; m_lrv = 1'b1; m_run = 1; m_lvl = s;
            end else begin
                m_run = sat(m_run);
            end
            for (int i = SYNC_STAGES; i > 0; i--) m_hist[i] = m_hist[i-1];
            m_hist[0] = z;
        end
    endtask

    // Driver tasks
    task automatic cycle(input bit r, input bit c, input bit z);
        @(negedge clk);
        rst_n = r; clr = c; zn = z;
        @(posedge clk);
        model_step(r, c, z);
        exp_q.push_back({m_lvl, m_lv, m_rp, m_fp, m_lrv,
                         CNT_W'(m_rise), CNT_W'(m_fall), CNT_W'(m_run), CNT_W'(m_last)});
        if (m_rp || m_fp)
            ev_q.push_back({m_rp, CNT_W'(m_rise), CNT_W'(m_fall), CNT_W'(m_last)});
    endtask

    task automatic hold(input bit z, input int n);
        repeat (n) cycle(1'b1, 1'b0, z);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
        end
    endtask

    // Monitor: per-cycle snapshot and per-edge event comparison
    logic [SW-1:0] dut_snap;
    assign dut_snap = {level, level_valid, rise_pulse, fall_pulse, last_run_valid,
                       rise_cnt, fall_cnt, run_len, last_run};

    initial begin
        logic [SW-1:0] es;
        logic [EW-1:0] ee;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                es = exp_q.pop_front();
                n_cmp++;
                if (dut_snap !== es) begin
                    n_bad++;
                    $display("FAIL snapshot at %0t: got %h expected %h", $time, dut_snap, es);
                end
            end
            if (rise_pulse === 1'b1 || fall_pulse === 1'b1) begin
                n_cmp++;
                if (ev_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL edge_event at %0t: got unexpected pulse, expected none", $time);
                end else begin
                    ee = ev_q.pop_front();
                    if ({rise_pulse, rise_cnt, fall_cnt, last_run} !== ee || last_run_valid !== 1'b1) begin
                        n_bad++;
                        $display("FAIL edge_event at %0t: got %h lrv=%b expected %h lrv=1", $time,
                                 {rise_pulse, rise_cnt, fall_cnt, last_run}, last_run_valid, ee);
                    end
                end
            end
        end
    end

    // Stimulus
    initial begin
        int rc0;
        bit rz, rr, rcl;
        int rlen;
        rst_n = 1'b0; clr = 1'b0; zn = 1'b1;

        // Reset with zn high
        repeat (3) cycle(1'b0, 1'b0, 1'b1);
        #1;
        chk("rst_level", level, 0);
        chk("rst_level_valid", level_valid, 0);
        chk("rst_rise_cnt", rise_cnt, 0);
        chk("rst_fall_cnt", fall_cnt, 0);
        chk("rst_run_len", run_len, 0);
        chk("rst_last_run", last_run, 0);
        chk("rst_state", state_dbg, IDLE);
        cycle(1'b1, 1'b0, 1'b1);
        #1;
        chk("release_level_valid", level_valid, 1);
        repeat (LAT) cycle(1'b1, 1'b0, 1'b1);
        #1;
        chk("release_level", level, 1);

        // Toggle pattern from a cleared, settled low level
        hold(1'b0, 8);
        cycle(1'b1, 1'b1, 1'b0);
        hold(1'b0, 3);
        begin
            bit pat[11] = '{0, 1, 0, 1, 0, 0, 1, 1, 1, 0, 0};
            for (int i = 0; i < 11; i++) hold(pat[i], 5);
        end
        #1;
        chk("toggle_rise_cnt", rise_cnt, 3);
        chk("toggle_fall_cnt", fall_cnt, 3);

        // Run length: 7 cycles low, then high
        hold(1'b1, 8);
        cycle(1'b1, 1'b1, 1'b1);
        hold(1'b1, 4);
        hold(1'b0, 7);
        hold(1'b1, LAT + 3);
        #1;
        chk("run_last_run", last_run, 7);
        chk("run_len_after_rise", run_len, 3);

        // Saturation
        hold(1'b0, 6);
        cycle(1'b1, 1'b1, 1'b0);
        hold(1'b0, 3);
        repeat (20) begin
            hold(1'b1, 3);
            hold(1'b0, 3);
        end
        hold(1'b0, LAT + 2);
        #1;
        chk("sat_rise_cnt", rise_cnt, MAXV);
        chk("sat_fall_cnt", fall_cnt, MAXV);
        hold(1'b0, 30);
        #1;
        chk("sat_run_len", run_len, MAXV);

        // clr on the very edge that would accept a rise
        repeat (LAT) cycle(1'b1, 1'b0, 1'b1);
        cycle(1'b1, 1'b1, 1'b1);
        #1;
        chk("coll_rise_pulse", rise_pulse, 0);
        chk("coll_rise_cnt", rise_cnt, 0);
        chk("coll_fall_cnt", fall_cnt, 0);
        chk("coll_level_valid", level_valid, 0);
        chk("coll_state", state_dbg, IDLE);
        cycle(1'b1, 1'b0, 1'b1);
        #1;
        chk("coll_level_valid_next", level_valid, 1);
        chk("coll_level_next", level, 1);

        // Glitches: one-cycle pulse then two-cycle pulse
        hold(1'b0, 8);
        #1;
        rc0 = int'(rise_cnt);
        hold(1'b1, 1);
        hold(1'b0, 8);
        hold(1'b1, 2);
        hold(1'b0, 8);
        #1;
        chk("glitch_rise_delta", int'(rise_cnt) - rc0, FILT ? 1 : 2);

        // Random traffic with occasional clr and reset
        for (int i = 0; i < 150; i++) begin
            rz   = 1'($urandom_range(0, 1));
            rlen = $urandom_range(1, 6);
            for (int k = 0; k < rlen; k++) begin
                rr  = ($urandom_range(0, 99) != 0);
                rcl = ($urandom_range(0, 29) == 0);
                cycle(rr, rcl, rz);
            end
        end
        hold(1'b0, LAT + 4);

        @(negedge clk);
        @(negedge clk);
        chk("event_queue_drained", ev_q.size(), 0);
        chk("snapshot_queue_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
